// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: per-stage reset/enable from hazards, branches,
// memory waits and debug single-step, plus stall/flush event counters.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        debug_en,
  input  logic        debug_step,
  input  logic        rs_used_id,
  input  logic        rt_used_id,
  input  logic [4:0]  addr_rs_id,
  input  logic [4:0]  addr_rt_id,
  input  logic        is_branch_id,
  input  logic        is_branch_exe,
  input  logic        is_branch_mem,
  input  logic [4:0]  regw_addr_exe,
  input  logic [4:0]  regw_addr_mem,
  input  logic [4:0]  regw_addr_wb,
  input  logic        wb_wen_exe,
  input  logic        wb_wen_mem,
  input  logic        wb_wen_wb,
  input  logic        mem_ren_mem,
  input  logic        mem_wen_mem,
  input  logic        mem_ack,
  output logic        if_rst,
  output logic        if_en,
  output logic        id_rst,
  output logic        id_en,
  output logic        exe_rst,
  output logic        exe_en,
  output logic        mem_rst,
  output logic        mem_en,
  output logic        wb_rst,
  output logic        wb_en,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  // Bit order: if_rst,if_en,id_rst,id_en,exe_rst,exe_en,mem_rst,mem_en,wb_rst,wb_en
  localparam logic [9:0] C_RESET  = 10'b10_10_10_10_10;
  localparam logic [9:0] C_NORMAL = 10'b01_01_01_01_01;
  localparam logic [9:0] C_MWAIT  = 10'b00_00_00_00_11;
  localparam logic [9:0] C_BRMEM  = 10'b01_10_01_01_01;
  localparam logic [9:0] C_HAZARD = 10'b00_00_10_01_01;
  localparam logic [9:0] C_BRANCH = 10'b00_10_01_01_01;
  localparam logic [9:0] C_IDLE   = 10'b00_00_00_00_00;

  state_t     st;
  logic [1:0] rst_cnt;
  logic       step_q;
  logic       hazard, memwait, step_pulse, run_stall, run_flush, cnt_en;
  logic [9:0] run_ctrl, ctrl;

  function automatic logic match(input logic [4:0] a, input logic we_e, input logic [4:0] wa_e,
                                 input logic we_m, input logic [4:0] wa_m,
                                 input logic we_w, input logic [4:0] wa_w);
    return (we_e && wa_e == a) || (we_m && wa_m == a) || (we_w && wa_w == a);
  endfunction

  always_comb begin
    hazard  = (rs_used_id && addr_rs_id != 5'd0 &&
               match(addr_rs_id, wb_wen_exe, regw_addr_exe, wb_wen_mem, regw_addr_mem,
                     wb_wen_wb, regw_addr_wb)) ||
              (rt_used_id && addr_rt_id != 5'd0 &&
               match(addr_rt_id, wb_wen_exe, regw_addr_exe, wb_wen_mem, regw_addr_mem,
                     wb_wen_wb, regw_addr_wb));
    memwait    = (mem_ren_mem || mem_wen_mem) && !mem_ack;
    step_pulse = debug_step && !step_q;
    run_stall  = 1'b0;
    run_flush  = 1'b0;
    if (memwait)                            run_ctrl = C_MWAIT;
    else if (is_branch_mem)    begin        run_ctrl = C_BRMEM;  run_flush = 1'b1; end
    else if (hazard)           begin        run_ctrl = C_HAZARD; run_stall = 1'b1; end
    else if (is_branch_id || is_branch_exe) begin run_ctrl = C_BRANCH; run_flush = 1'b1; end
    else                                    run_ctrl = C_NORMAL;
  end

  // Counters advance only in cycles where the S_RUN rules actually drive the pipe.
  assign cnt_en = (st == S_RUN) || (st == S_HALT && step_pulse);

  always_comb begin
    ctrl = C_IDLE;
    case (st)
      S_RESET:    ctrl = C_RESET;
      S_RUN:      ctrl = run_ctrl;
      S_MEM_WAIT: ctrl = memwait ? C_MWAIT : C_NORMAL;
      S_HALT:     ctrl = step_pulse ? run_ctrl : C_IDLE;
      default:    ctrl = C_RESET;
    endcase
  end

  assign {if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en} = ctrl;
  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_RESET;
      rst_cnt   <= 2'd0;
      step_q    <= 1'b0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      step_q <= debug_step;
      if (cnt_en && run_stall) stall_cnt <= stall_cnt + 32'd1;
      if (cnt_en && run_flush) flush_cnt <= flush_cnt + 32'd1;
      case (st)
        S_RESET: begin
          if (rst_cnt == 2'd1) st <= S_RUN;
          else                 rst_cnt <= rst_cnt + 2'd1;
        end
        S_RUN: begin
          if (memwait)       st <= S_MEM_WAIT;
          else if (debug_en) st <= S_HALT;
        end
        S_MEM_WAIT: begin
          if (!memwait) st <= debug_en ? S_HALT : S_RUN;
        end
        S_HALT: begin
          if (step_pulse && memwait) st <= S_MEM_WAIT;
          else if (!debug_en)        st <= S_RUN;
        end
        default: st <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, then randomized cycles
// checked against a rule-level reference model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, debug_en, debug_step, rs_used_id, rt_used_id;
  logic [4:0] addr_rs_id, addr_rt_id, regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic is_branch_id, is_branch_exe, is_branch_mem;
  logic wb_wen_exe, wb_wen_mem, wb_wen_wb, mem_ren_mem, mem_wen_mem, mem_ack;
  logic if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0] state;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id),
    .is_branch_id(is_branch_id), .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
    .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem), .mem_ack(mem_ack),
    .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
    .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
    .wb_rst(wb_rst), .wb_en(wb_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  // if_rst,if_en,id_rst,id_en,exe_rst,exe_en,mem_rst,mem_en,wb_rst,wb_en
  localparam logic [9:0] X_RST = 10'b1010101010;
  localparam logic [9:0] X_NRM = 10'b0101010101;
  localparam logic [9:0] X_MW  = 10'b0000000011;
  localparam logic [9:0] X_BRM = 10'b0110010101;
  localparam logic [9:0] X_HZ  = 10'b0000100101;
  localparam logic [9:0] X_BR  = 10'b0010010101;
  localparam logic [9:0] X_IDL = 10'b0000000000;

  typedef struct {
    logic r, de, ds, ru, tu, ren, wen, ack;
    logic [2:0] br;          // {id, exe, mem}
    logic [2:0] we;          // {exe, mem, wb}
    logic [4:0] ars, art, wa_e, wa_m, wa_w;
    logic [9:0] e_ctrl;
    logic [1:0] e_st;
    logic [31:0] e_stall, e_flush;
  } vec_t;

  int errors = 0, checks = 0;
  vec_t tbl[$];

  // hz=1 gives an rs read of r5 while EXE writes r5
  function automatic vec_t V(logic r, logic de, logic ds, logic [2:0] br, logic hz,
                             logic [1:0] mem, logic ack, logic [9:0] ec, logic [1:0] es,
                             int stl, int fl);
    vec_t v;
    v.r = r; v.de = de; v.ds = ds; v.br = br;
    v.ru = hz; v.ars = hz ? 5'd5 : 5'd0; v.tu = 1'b0; v.art = 5'd0;
    v.we = hz ? 3'b100 : 3'b000; v.wa_e = hz ? 5'd5 : 5'd0; v.wa_m = 5'd0; v.wa_w = 5'd0;
    v.ren = mem[1]; v.wen = mem[0]; v.ack = ack;
    v.e_ctrl = ec; v.e_st = es; v.e_stall = stl; v.e_flush = fl;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, got, want);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.r; debug_en = v.de; debug_step = v.ds;
    rs_used_id = v.ru; rt_used_id = v.tu; addr_rs_id = v.ars; addr_rt_id = v.art;
    {is_branch_id, is_branch_exe, is_branch_mem} = v.br;
    {wb_wen_exe, wb_wen_mem, wb_wen_wb} = v.we;
    regw_addr_exe = v.wa_e; regw_addr_mem = v.wa_m; regw_addr_wb = v.wa_w;
    mem_ren_mem = v.ren; mem_wen_mem = v.wen; mem_ack = v.ack;
  endtask

  // drive at negedge, compare 1 time unit later, then let the posedge happen
  task automatic apply(vec_t v, int idx);
    drive(v);
    #1;
    chk("ctrl", idx, {22'd0, if_rst, if_en, id_rst, id_en, exe_rst, exe_en,
                      mem_rst, mem_en, wb_rst, wb_en}, {22'd0, v.e_ctrl});
    chk("state", idx, {30'd0, state}, {30'd0, v.e_st});
    chk("stall_cnt", idx, stall_cnt, v.e_stall);
    chk("flush_cnt", idx, flush_cnt, v.e_flush);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---- reference model: spec rules at the level of named actions ----
  typedef enum int {A_RST, A_NRM, A_MW, A_BRM, A_HZ, A_BR, A_IDL} act_t;
  int m_mode;                // 0 reset, 1 run, 2 mem wait, 3 halt
  int m_rcycles;             // reset cycles already spent
  logic [31:0] m_stall, m_flush;
  logic m_stepq;

  function automatic bit reads_hazard(logic used, logic [4:0] a, vec_t v);
    logic [4:0] dst [3];
    dst[0] = v.wa_e; dst[1] = v.wa_m; dst[2] = v.wa_w;
    if (!used || a == 0) return 0;
    for (int s = 0; s < 3; s++)
      if (v.we[2-s] && dst[s] == a) return 1;
    return 0;
  endfunction

  function automatic act_t run_rules(vec_t v);
    bit mw = (v.ren || v.wen) && !v.ack;
    bit hz = reads_hazard(v.ru, v.ars, v) || reads_hazard(v.tu, v.art, v);
    if (mw) return A_MW;
    if (v.br[0]) return A_BRM;
    if (hz) return A_HZ;
    if (v.br[2] || v.br[1]) return A_BR;
    return A_NRM;
  endfunction

  function automatic logic [9:0] act_bits(act_t a);
    case (a)
      A_RST: return X_RST;
      A_NRM: return X_NRM;
      A_MW:  return X_MW;
      A_BRM: return X_BRM;
      A_HZ:  return X_HZ;
      A_BR:  return X_BR;
      default: return X_IDL;
    endcase
  endfunction

  task automatic model_cycle(vec_t v, int idx);
    bit mw = (v.ren || v.wen) && !v.ack;
    bit step = v.ds && !m_stepq;
    bit ruled = (m_mode == 1) || (m_mode == 3 && step);
    act_t a;
    int nxt = m_mode;
    case (m_mode)
      0: a = A_RST;
      1: a = run_rules(v);
      2: a = mw ? A_MW : A_NRM;
      default: a = step ? run_rules(v) : A_IDL;
    endcase
    v.e_ctrl = act_bits(a); v.e_st = m_mode[1:0];
    v.e_stall = m_stall; v.e_flush = m_flush;
    apply(v, idx);
    if (v.r) begin
      m_mode = 0; m_rcycles = 0; m_stall = 0; m_flush = 0; m_stepq = 0;
    end else begin
      if (ruled && a == A_HZ) m_stall++;
      if (ruled && (a == A_BRM || a == A_BR)) m_flush++;
      case (m_mode)
        0: begin m_rcycles++; if (m_rcycles == 2) nxt = 1; end
        1: nxt = mw ? 2 : (v.de ? 3 : 1);
        2: nxt = mw ? 2 : (v.de ? 3 : 1);
        default: nxt = (step && mw) ? 2 : (!v.de ? 1 : 3);
      endcase
      m_mode = nxt;
      m_stepq = v.ds;
    end
  endtask

  function automatic vec_t rnd(logic de);
    vec_t v;
    v.r = ($urandom % 64) == 0; v.de = de; v.ds = ($urandom % 3) == 0;
    v.ru = $urandom; v.tu = $urandom;
    v.ars = $urandom % 8; v.art = $urandom % 8;
    v.we = $urandom; v.wa_e = $urandom % 8; v.wa_m = $urandom % 8; v.wa_w = $urandom % 8;
    v.br = {($urandom % 6) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0};
    v.ren = ($urandom % 4) == 0; v.wen = ($urandom % 4) == 0; v.ack = $urandom;
    v.e_ctrl = 0; v.e_st = 0; v.e_stall = 0; v.e_flush = 0;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic de;
    drive(V(1,0,0,0,0,0,0,X_RST,0,0,0));
    @(posedge clk); @(negedge clk);

    tbl.push_back(V(1,0,0,3'b000,0,2'b00,0,X_RST,0,0,0));   // 0 reset state
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_RST,0,0,0));
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_RST,0,0,0));
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_NRM,1,0,0));   // 3 run on 3rd cycle
    tbl.push_back(V(0,0,0,3'b000,1,2'b00,0,X_HZ,1,0,0));    // 4 rs hazard
    v = V(0,0,0,3'b000,1,2'b00,0,X_NRM,1,1,0); v.ars = 0; tbl.push_back(v);  // r0 never hazards
    v = V(0,0,0,3'b000,0,2'b00,0,X_HZ,1,1,0);                // rs+rt hazard: one stall
    v.ru = 1; v.ars = 3; v.we = 3'b011; v.wa_m = 3; v.tu = 1; v.art = 7; v.wa_w = 7;
    tbl.push_back(v);
    v = V(0,0,0,3'b000,1,2'b00,0,X_NRM,1,2,0); v.ru = 0; tbl.push_back(v);   // not read
    tbl.push_back(V(0,0,0,3'b100,0,2'b00,0,X_BR,1,2,0));    // 8 branch id/exe/mem
    tbl.push_back(V(0,0,0,3'b010,0,2'b00,0,X_BR,1,2,1));
    tbl.push_back(V(0,0,0,3'b001,0,2'b00,0,X_BRM,1,2,2));
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_NRM,1,2,3));
    tbl.push_back(V(0,0,0,3'b001,1,2'b00,0,X_BRM,1,2,3));   // 12 br_mem beats hazard
    tbl.push_back(V(0,0,0,3'b100,1,2'b00,0,X_HZ,1,2,4));    // hazard beats br_id
    tbl.push_back(V(0,0,0,3'b000,0,2'b10,0,X_MW,1,3,4));    // 14 mem wait
    tbl.push_back(V(0,0,0,3'b000,1,2'b10,0,X_MW,2,3,4));
    tbl.push_back(V(0,0,0,3'b000,0,2'b01,0,X_MW,2,3,4));
    tbl.push_back(V(0,0,0,3'b000,0,2'b10,0,X_MW,2,3,4));
    tbl.push_back(V(0,0,0,3'b000,0,2'b10,1,X_NRM,2,3,4));   // 18 ack cycle
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_NRM,1,3,4));
    tbl.push_back(V(0,1,0,3'b000,0,2'b00,0,X_NRM,1,3,4));   // 20 halt request
    tbl.push_back(V(0,1,0,3'b000,0,2'b00,0,X_IDL,3,3,4));
    tbl.push_back(V(0,1,1,3'b000,0,2'b00,0,X_NRM,3,3,4));   // 22 step
    tbl.push_back(V(0,1,1,3'b000,0,2'b00,0,X_IDL,3,3,4));   // held step: nothing
    tbl.push_back(V(0,1,0,3'b000,0,2'b00,0,X_IDL,3,3,4));
    tbl.push_back(V(0,1,1,3'b100,0,2'b00,0,X_BR,3,3,4));    // 25 step with branch counts
    tbl.push_back(V(0,1,0,3'b000,0,2'b00,0,X_IDL,3,3,5));
    tbl.push_back(V(0,1,1,3'b000,0,2'b10,0,X_MW,3,3,5));    // 27 step into mem wait
    tbl.push_back(V(0,1,0,3'b000,0,2'b10,0,X_MW,2,3,5));
    tbl.push_back(V(0,1,0,3'b000,0,2'b10,1,X_NRM,2,3,5));   // back to halt
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_IDL,3,3,5));   // 30 leave halt
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_NRM,1,3,5));
    tbl.push_back(V(0,0,0,3'b000,0,2'b10,0,X_MW,1,3,5));
    tbl.push_back(V(1,0,0,3'b000,0,2'b10,0,X_MW,2,3,5));    // 33 rst during mem wait
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_RST,0,0,0));
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_RST,0,0,0));
    tbl.push_back(V(0,0,0,3'b000,0,2'b00,0,X_NRM,1,0,0));
    tbl.push_back(V(0,1,0,3'b000,0,2'b00,0,X_NRM,1,0,0));
    tbl.push_back(V(1,1,0,3'b000,0,2'b00,0,X_IDL,3,0,0));   // 38 rst during halt
    tbl.push_back(V(1,0,0,3'b000,0,2'b00,0,X_RST,0,0,0));

    foreach (tbl[i]) apply(tbl[i], i);

    // model starts in the state the last (reset) vector left behind
    m_mode = 0; m_rcycles = 0; m_stall = 0; m_flush = 0; m_stepq = 0;

    // seven stalls, then reset in the middle of a memory wait
    for (int i = 0; i < 2; i++) model_cycle(V(0,0,0,0,0,0,0,0,0,0,0), 1000 + i);
    for (int i = 0; i < 7; i++) model_cycle(V(0,0,0,0,1,0,0,0,0,0,0), 1010 + i);
    model_cycle(V(0,0,0,0,0,2'b10,0,0,0,0,0), 1020);
    model_cycle(V(0,0,0,0,0,2'b10,0,0,0,0,0), 1021);
    model_cycle(V(1,0,0,0,0,2'b10,0,0,0,0,0), 1022);
    model_cycle(V(0,0,0,0,0,0,0,0,0,0,0), 1023);
    chk("stall_after_rst", 1023, stall_cnt, 32'd0);

    de = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (($urandom % 16) == 0) de = ~de;
      model_cycle(rnd(de), 2000 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL provide one clock and synchronous active-high reset: clk, rst; all state updates on posedge clk, rst sampled only at posedge clk.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  main clock
- rst  in  1  synchronous active-high reset
- debug_en  in  1  halt pipeline for single-step
- debug_step  in  1  step request, rising-edge detected
- rs_used_id, rt_used_id  in  1 each  ID instruction reads rs/rt
- addr_rs_id, addr_rt_id  in  5 each  ID source register numbers
- is_branch_id  in  1  ID instruction is jump/branch (from decoder)
- is_branch_exe, is_branch_mem  in  1 each  jump/branch in EXE/MEM
- regw_addr_exe, regw_addr_mem, regw_addr_wb  in  5 each  destination register per stage
- wb_wen_exe, wb_wen_mem, wb_wen_wb  in  1 each  register write enable per stage
- mem_ren_mem, mem_wen_mem  in  1 each  MEM-stage memory access
- mem_ack  in  1  memory access completes this cycle
- if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en  out  1 each  per-stage reset/enable
- stall_cnt  out  32  data-hazard stall cycles
- flush_cnt  out  32  control-flush cycles
- state  out  2  FSM state, for debug

Function
REQ-003 FSM states SHALL be S_RESET=0, S_RUN=1, S_MEM_WAIT=2, S_HALT=3.
REQ-004 S_RESET SHALL assert all five *_rst, deassert all *_en, and remain for exactly 2 cycles after rst falls (2-bit counter), then go to S_RUN.
REQ-005 hazard SHALL = (rs_used_id & addr_rs_id!=0 & match(addr_rs_id)) | (rt_used_id & addr_rt_id!=0 & match(addr_rt_id)); match(a) = any stage X in {exe,mem,wb} with wb_wen_X & regw_addr_X==a.
REQ-006 memwait SHALL = (mem_ren_mem | mem_wen_mem) & ~mem_ack.
REQ-007 In S_RUN, action SHALL follow priority memwait > is_branch_mem > hazard > (is_branch_id|is_branch_exe) > normal.
REQ-008 Normal SHALL assert every *_en and deassert every *_rst.
REQ-009 memwait SHALL: all *_en=0 except wb_en=1, wb_rst=1 (WB bubble, no double write), all other *_rst=0; next state S_MEM_WAIT.
REQ-010 S_MEM_WAIT SHALL hold REQ-009 outputs while memwait; in the cycle memwait=0, outputs SHALL be normal (REQ-008) and next state S_RUN, or S_HALT if debug_en.
REQ-011 is_branch_mem SHALL: if_en=1 (PC takes target), id_rst=1, exe/mem/wb enabled; flush_cnt+1.
REQ-012 hazard SHALL: if_en=0, id_en=0, exe_rst=1 (EXE bubble), mem_en=wb_en=1; stall_cnt+1.
REQ-013 is_branch_id|is_branch_exe SHALL: if_en=0, id_rst=1, other stages enabled; flush_cnt+1. Branch yields exactly 3 ID bubbles before target enters ID.
REQ-014 In S_RUN with debug_en=1 and no memwait, next state SHALL be S_HALT; that cycle's action still completes.
REQ-015 S_HALT SHALL deassert all *_en and *_rst; step_pulse = debug_step & ~debug_step_q SHALL produce exactly one cycle of S_RUN-rule outputs (REQ-007) while remaining in S_HALT, or moving to S_MEM_WAIT if memwait; debug_en=0 returns to S_RUN.
REQ-016 Counters SHALL wrap modulo 2^32, count only in S_RUN or step cycles, never in S_RESET/S_MEM_WAIT.
REQ-017 Register 0 SHALL never cause a hazard; simultaneous rs and rt hazard SHALL count one stall cycle.

Reset
REQ-018 rst=1 at any edge, including mid S_MEM_WAIT or S_HALT, SHALL force S_RESET, clear the reset counter, stall_cnt, flush_cnt, debug_step_q; outputs SHALL be all *_rst=1, all *_en=0, state=0.

Verification
REQ-019 rst 1 cycle then low -> stage resets held 2 more cycles, state=1 on the 3rd cycle, all *_en=1.
REQ-020 wb_wen_exe=1, regw_addr_exe=5, rs_used_id=1, addr_rs_id=5 for 1 cycle -> if_en=id_en=0, exe_rst=1, stall_cnt=1; with addr_rs_id=0 -> no stall.
REQ-021 is_branch_id 1 cycle, then is_branch_exe, then is_branch_mem -> id_rst=1 for 3 cycles, if_en=0,0,1, flush_cnt=3.
REQ-022 mem_ren_mem=1, mem_ack low 4 cycles -> state=2 for 4 cycles, wb_rst=1, other *_en=0; ack cycle all *_en=1, then state=1.
REQ-023 debug_en=1 -> state=3, all *_en=0; two debug_step pulses -> exactly two cycles of *_en=1; held-high step -> one cycle only.
REQ-024 rst asserted during S_MEM_WAIT with stall_cnt=7 -> next cycle state=0, stall_cnt=0, all *_rst=1.
